// File: rtl/seg_pkg.sv
// Shared display definitions: hex segment table, dark-output constants and scan FSM encoding.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] DRV_OFF   = 4'hF;

  // Active-high g..a patterns for hex 0..F; index 0 is the leftmost entry.
  localparam logic [0:15][6:0] SEG_TABLE = {
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  typedef struct packed {
    logic [3:0]  dp;
    logic [15:0] digits;
  } disp_word_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Hex digit plus decimal point to active-low seven-segment pattern.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dp,
  output logic [7:0] seg_c
);

  always_comb begin
    seg_c = ~{dp, SEG_TABLE[digit]};
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan scheduler with per-slot blanking, PWM dimming
// and frame-synchronous display updates.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned CLKS_PER_SLOT = 100000,
  parameter int unsigned BLANK_CYCLES  = 1000
) (
  input  logic        Clk_100M,
  input  logic        nReset,
  input  logic [15:0] Digits,
  input  logic [3:0]  DP_In,
  input  logic [3:0]  Brightness,
  input  logic        Load,
  output logic [3:0]  SegmentDrivers,
  output logic [7:0]  SevenSegment,
  output logic        FrameDone
);

  localparam int unsigned CW = $clog2(CLKS_PER_SLOT);

  logic [CW-1:0] slot_cnt;
  logic [1:0]    digit_idx;
  state_t        state, state_nx;
  disp_word_t    staging, shadow;
  logic          pending;

  logic          slot_end_c, frame_end_c, lit_c;
  logic [3:0]    digit_sel_c;
  logic          dp_sel_c;
  logic [7:0]    seg_c;
  logic [3:0]    drv_c;

  assign slot_end_c  = (slot_cnt == CW'(CLKS_PER_SLOT - 1));
  assign frame_end_c = slot_end_c && (digit_idx == 2'd3);

  // Slot and digit position counters.
  always_ff @(posedge Clk_100M or negedge nReset) begin
    if (!nReset) begin
      slot_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (slot_end_c) begin
      slot_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      slot_cnt  <= slot_cnt + CW'(1);
    end
  end

  always_ff @(posedge Clk_100M or negedge nReset) begin
    if (!nReset) state <= BLANK;
    else         state <= state_nx;
  end

  // The exit cycle of DRIVE stays dark so the registered outputs show a full
  // BLANK_CYCLES+1 dark window at the start of every slot.
  always_comb begin
    state_nx = state;
    lit_c    = 1'b0;
    case (state)
      BLANK: begin
        if (slot_cnt == CW'(BLANK_CYCLES - 1)) state_nx = DRIVE;
      end
      DRIVE: begin
        if (slot_end_c) state_nx = BLANK;
        else            lit_c    = (slot_cnt[3:0] < Brightness);
      end
    endcase
  end

  // Staged load; shadow only changes at a frame wrap so a frame never tears.
  always_ff @(posedge Clk_100M or negedge nReset) begin
    if (!nReset) begin
      staging <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else if (frame_end_c) begin
      pending <= 1'b0;
      if (Load)         shadow <= '{dp: DP_In, digits: Digits};
      else if (pending) shadow <= staging;
    end else if (Load) begin
      staging <= '{dp: DP_In, digits: Digits};
      pending <= 1'b1;
    end
  end

  assign digit_sel_c = shadow.digits[{digit_idx, 2'b00} +: 4];
  assign dp_sel_c    = shadow.dp[digit_idx];
  assign drv_c       = ~(4'b0001 << digit_idx);

  seg_hex_decode u_dec (
    .digit (digit_sel_c),
    .dp    (dp_sel_c),
    .seg_c (seg_c)
  );

  always_ff @(posedge Clk_100M or negedge nReset) begin
    if (!nReset) begin
      SegmentDrivers <= DRV_OFF;
      SevenSegment   <= SEG_BLANK;
      FrameDone      <= 1'b0;
    end else begin
      SegmentDrivers <= lit_c ? drv_c : DRV_OFF;
      SevenSegment   <= lit_c ? seg_c : SEG_BLANK;
      FrameDone      <= frame_end_c;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a cycle-index reference model.
module tb_seg_scan_ctrl;

  localparam int unsigned CPS   = 40;
  localparam int unsigned BLK   = 8;
  localparam int unsigned FRAME = 4 * CPS;

  logic        Clk_100M = 1'b0;
  logic        nReset;
  logic [15:0] Digits;
  logic [3:0]  DP_In;
  logic [3:0]  Brightness;
  logic        Load;
  logic [3:0]  SegmentDrivers;
  logic [7:0]  SevenSegment;
  logic        FrameDone;

  seg_scan_ctrl #(.CLKS_PER_SLOT(CPS), .BLANK_CYCLES(BLK)) dut (
    .Clk_100M       (Clk_100M),
    .nReset         (nReset),
    .Digits         (Digits),
    .DP_In          (DP_In),
    .Brightness     (Brightness),
    .Load           (Load),
    .SegmentDrivers (SegmentDrivers),
    .SevenSegment   (SevenSegment),
    .FrameDone      (FrameDone)
  );

  always #5 Clk_100M = ~Clk_100M;

  int vectors     = 0;
  int miscompares = 0;
  int g           = 0;
  int phase       = 1;
  int load_g[$];
  logic [19:0] load_v[$];

  task automatic check_vec(input string tag, input logic [12:0] got, input logic [12:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got drv/seg/fd=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Last load issued in any cycle before frame f started.
  function automatic logic [19:0] shadow_for(input int f);
    logic [19:0] s = '0;
    foreach (load_g[i]) if (load_g[i] < int'(FRAME) * f) s = load_v[i];
    return s;
  endfunction

  // Outputs visible after the edge that ends global cycle gc.
  function automatic logic [12:0] expect_at(input int gc, input logic [3:0] br);
    int p = gc % CPS;
    int d = (gc / CPS) % 4;
    int f = gc / FRAME;
    logic fd = ((gc % FRAME) == FRAME - 1);
    logic lit = (p >= BLK) && (p != CPS - 1) && ((p % 16) < int'(br));
    logic [3:0]  drv = 4'hF;
    logic [7:0]  seg = 8'hFF;
    logic [19:0] sh;
    if (lit) begin
      sh  = shadow_for(f);
      drv = 4'hF ^ 4'(1 << d);
      seg = ~{sh[16 + d], hex7(sh[4*d +: 4])};
    end
    return {drv, seg, fd};
  endfunction

  task automatic drive_inputs();
    Load = 1'b0;
    if (phase == 1) begin
      if (g == 5)        begin Load = 1'b1; Digits = 16'h1234; DP_In = 4'b0000; end
      else if (g == 200) begin Load = 1'b1; Digits = 16'h00AA; DP_In = 4'b0000; end
      else if (g == 250) begin Load = 1'b1; Digits = 16'h5555; DP_In = 4'b0000; end
      else if (g == 479) begin Load = 1'b1; Digits = 16'h8888; DP_In = 4'b0001; end
      else if (g > 640 && (((g % FRAME) == FRAME - 1 && $urandom_range(0, 1) == 1)
                           || $urandom_range(0, 49) == 0)) begin
        Load = 1'b1; Digits = 16'($urandom); DP_In = 4'($urandom);
      end
      if (g == 800)      Brightness = 4'd4;
      else if (g == 960) Brightness = 4'd0;
      else if (g >= 1120 && g < 1500 && (g % FRAME) == 0) Brightness = 4'($urandom);
      else if (g >= 1500) Brightness = 4'd15;
    end else if (g > 100 && $urandom_range(0, 39) == 0) begin
      Load = 1'b1; Digits = 16'($urandom); DP_In = 4'($urandom);
    end
  endtask

  task automatic step();
    logic [3:0] br;
    @(posedge Clk_100M);
    br = Brightness;
    if (Load) begin
      load_g.push_back(g);
      load_v.push_back({DP_In, Digits});
    end
    #1;
    check_vec($sformatf("p%0d_g%0d", phase, g), {SegmentDrivers, SevenSegment, FrameDone},
              expect_at(g, br));
    g++;
    drive_inputs();
  endtask

  initial begin
    nReset = 1'b0; Load = 1'b0; Digits = '0; DP_In = '0; Brightness = 4'd15;
    repeat (3) @(posedge Clk_100M);
    #1;
    check_vec("reset", {SegmentDrivers, SevenSegment, FrameDone}, {4'hF, 8'hFF, 1'b0});
    #2 nReset = 1'b1;
    drive_inputs();
    repeat (1600) step();
    for (int k = 0; k < int'(CPS) && (g % CPS) != 20; k++) step();

    // Asynchronous reset in the middle of a lit DRIVE phase.
    #2 nReset = 1'b0;
    #1;
    check_vec("rst_async", {SegmentDrivers, SevenSegment, FrameDone}, {4'hF, 8'hFF, 1'b0});
    repeat (2) begin
      @(posedge Clk_100M);
      #1;
      check_vec("rst_hold", {SegmentDrivers, SevenSegment, FrameDone}, {4'hF, 8'hFF, 1'b0});
    end
    Load = 1'b0; Digits = '0; DP_In = '0; Brightness = 4'd15;
    load_g.delete();
    load_v.delete();
    g = 0;
    phase = 2;
    #2 nReset = 1'b1;
    repeat (480) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
